// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one word-aligned bus access at a time,
// stalls the pipeline while it is outstanding and returns extended load data.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_sel,
    input  logic [31:0] req_wdata,
    input  logic        req_usign,
    input  logic        req_exc,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        we_q, we_d;
    logic        usign_q, usign_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_wr_q, mem_wr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        bus_err_q, bus_err_d;
    logic        accept;
    logic        killed;
    logic        addr_lsb_unused;

    // Byte offset is carried by req_sel, so the low address bits are not needed.
    assign addr_lsb_unused = ^req_addr[1:0];

    function automatic logic [31:0] replicate(input logic [3:0] sel, input logic [31:0] w);
        logic [31:0] r;
        case (sel)
            4'b0011, 4'b1100: r = {2{w[15:0]}};
            4'b1111:          r = w;
            default:          r = {4{w[7:0]}};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [3:0] be, input logic us,
                                            input logic [31:0] rd);
        logic [31:0] r;
        case (be)
            4'b0001: r = us ? {24'b0, rd[7:0]}   : {{24{rd[7]}},  rd[7:0]};
            4'b0010: r = us ? {24'b0, rd[15:8]}  : {{24{rd[15]}}, rd[15:8]};
            4'b0100: r = us ? {24'b0, rd[23:16]} : {{24{rd[23]}}, rd[23:16]};
            4'b1000: r = us ? {24'b0, rd[31:24]} : {{24{rd[31]}}, rd[31:24]};
            4'b0011: r = us ? {16'b0, rd[15:0]}  : {{16{rd[15]}}, rd[15:0]};
            4'b1100: r = us ? {16'b0, rd[31:16]} : {{16{rd[31]}}, rd[31:16]};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign accept = req_valid & ~req_exc & ~flush & (req_sel != 4'b0000);
    // A flush landing in the completing cycle still squashes the result.
    assign killed = kill_q | flush;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        kill_d        = kill_q;
        we_d          = we_q;
        usign_d       = usign_q;
        mem_req_d     = mem_req_q;
        mem_wr_d      = mem_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        bus_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d     = BUSY;
                    cnt_d       = 8'd0;
                    kill_d      = 1'b0;
                    we_d        = req_we;
                    usign_d     = req_usign;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = req_we;
                    mem_addr_d  = {req_addr[31:2], 2'b00};
                    mem_be_d    = req_sel;
                    mem_wdata_d = replicate(req_sel, req_wdata);
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (flush) kill_d = 1'b1;
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    if (!we_q && !killed) begin
                        rdata_d       = extract(mem_be_q, usign_q, mem_rdata);
                        rdata_valid_d = 1'b1;
                    end
                end else if (cnt_q == LAST_CNT) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    mem_wr_d  = 1'b0;
                    bus_err_d = 1'b1;
                    if (!we_q && !killed) rdata_d = 32'd0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            kill_q        <= 1'b0;
            we_q          <= 1'b0;
            usign_q       <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_be_q      <= 4'd0;
            mem_wdata_q   <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            kill_q        <= kill_d;
            we_q          <= we_d;
            usign_q       <= usign_d;
            mem_req_q     <= mem_req_d;
            mem_wr_q      <= mem_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign stall       = ((state_q == IDLE) && accept) || (state_q == BUSY);
    assign mem_req     = mem_req_q;
    assign mem_wr      = mem_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan cases plus randomized accesses
// against a byte-lane arithmetic reference model.
module tb_mem_access_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_usign = 1'b0, req_exc = 1'b0, flush = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
    logic [3:0]  req_sel = '0;
    logic        mem_ack = 1'b0;
    logic        stall, rdata_valid, bus_err, mem_req, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_rdata = '0;
    logic [3:0]  sel_tab[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100};

    mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_sel(req_sel),
        .req_wdata(req_wdata), .req_usign(req_usign), .req_exc(req_exc), .flush(flush),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .bus_err(bus_err),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Lane value = bytes starting at the lowest enabled lane, width = enabled bytes.
    function automatic logic [31:0] model_ext(input logic [31:0] rd, input logic [3:0] sel,
                                              input logic us);
        int k = 0;
        int n = $countones(sel);
        longint mask, v;
        while (!sel[k]) k++;
        mask = (64'd1 << (8 * n)) - 1;
        v = (longint'(rd) >> (8 * k)) & mask;
        if (!us && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~mask;
        return v[31:0];
    endfunction

    // Byte lane i of the bus carries store byte (i mod access size).
    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [3:0] sel);
        int n = $countones(sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic clear_req();
        req_valid = 1'b0; req_exc = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    endtask

    // ack_dly: BUSY cycle index of the ack (-1 = never); flush_at likewise.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] wd, input logic us, input int ack_dly,
                              input int flush_at, input logic [31:0] rd);
        logic ack_ok, killed, exp_valid;
        int busy_len;
        ack_ok   = (ack_dly >= 0) && (ack_dly < TO);
        busy_len = ack_ok ? ack_dly + 1 : TO;
        killed   = (flush_at >= 0) && (flush_at < busy_len);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_sel = sel;
        req_wdata = wd; req_usign = us; req_exc = 1'b0; flush = 1'b0;
        #1 check("stall_accept", stall, 1'b1);
        for (int c = 0; c < busy_len; c++) begin
            @(negedge clk);
            req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
            req_sel = sel_tab[$urandom_range(0, 5)];
            check("busy_req", mem_req, 1'b1);
            check("busy_stall", stall, 1'b1);
            check("busy_wr", mem_wr, we);
            check("busy_addr", mem_addr, {addr[31:2], 2'b00});
            check("busy_be", mem_be, sel);
            if (we) check("busy_wdata", mem_wdata, model_wdata(wd, sel));
            mem_ack   = (c == ack_dly);
            mem_rdata = (c == ack_dly) ? rd : $urandom;
            flush     = (c == flush_at);
        end
        @(negedge clk);
        flush = 1'b0; mem_ack = $urandom_range(0, 1); mem_rdata = $urandom;
        if (!we && !killed) model_rdata = ack_ok ? model_ext(rd, sel, us) : 32'd0;
        exp_valid = !we && ack_ok && !killed;
        check("done_valid", rdata_valid, exp_valid);
        check("done_err", bus_err, !ack_ok);
        check("done_rdata", rdata, model_rdata);
        check("done_req", mem_req, 1'b0);
        check("done_wr", mem_wr, 1'b0);
        req_valid = 1'b1; req_sel = 4'b1111;
        #1 check("done_stall", stall, 1'b0);
        @(negedge clk);
        check("idle_req", mem_req, 1'b0);
        check("idle_valid", rdata_valid, 1'b0);
        check("idle_err", bus_err, 1'b0);
        clear_req();
    endtask

    task automatic no_access(input logic exc, input logic [3:0] sel, input logic fl);
        @(negedge clk);
        req_valid = 1'b1; req_we = $urandom_range(0, 1); req_addr = $urandom;
        req_sel = sel; req_exc = exc; flush = fl;
        #1 check("noacc_stall", stall, 1'b0);
        @(negedge clk);
        clear_req();
        check("noacc_req", mem_req, 1'b0);
        @(negedge clk);
        check("noacc_req2", mem_req, 1'b0);
        check("noacc_valid", rdata_valid, 1'b0);
        check("noacc_rdata", rdata, model_rdata);
    endtask

    task automatic reset_mid_busy();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_4000; req_sel = 4'b1111;
        @(negedge clk);
        clear_req();
        @(negedge clk);
        check("rst_pre_req", mem_req, 1'b1);
        resetn = 1'b0;
        model_rdata = 32'd0;
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_addr", mem_addr, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < TO + 2; i++) begin
            @(negedge clk);
            mem_ack = $urandom_range(0, 1);
            check("rst_post_valid", rdata_valid, 1'b0);
            check("rst_post_err", bus_err, 1'b0);
            check("rst_post_req", mem_req, 1'b0);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_stall", stall, 1'b0);
        check("reset_req", mem_req, 1'b0);
        check("reset_wr", mem_wr, 1'b0);
        check("reset_addr", mem_addr, 32'd0);
        check("reset_be", mem_be, 4'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_valid", rdata_valid, 1'b0);
        check("reset_err", bus_err, 1'b0);
        resetn = 1'b1;

        run_access(1'b0, 32'h0000_1003, 4'b1000, 32'h0, 1'b0, 2, -1, 32'h8012_3456);
        check("lb_value", rdata, 32'hFFFF_FF80);
        run_access(1'b0, 32'h0000_2002, 4'b1100, 32'h0, 1'b1, 0, -1, 32'h89AB_1234);
        check("lhu_value", rdata, 32'h0000_89AB);
        run_access(1'b0, 32'h0000_2002, 4'b1100, 32'h0, 1'b0, 0, -1, 32'h89AB_1234);
        check("lh_value", rdata, 32'hFFFF_89AB);
        run_access(1'b1, 32'h0000_0001, 4'b0010, 32'h1234_56EF, 1'b0, 1, -1, 32'h0);
        check("sb_rdata_kept", rdata, 32'hFFFF_89AB);
        no_access(1'b1, 4'b1111, 1'b0);
        no_access(1'b0, 4'b0000, 1'b0);
        no_access(1'b0, 4'b1111, 1'b1);
        run_access(1'b0, 32'h0000_3000, 4'b1111, 32'h0, 1'b0, -1, -1, 32'h0);
        check("timeout_rdata", rdata, 32'd0);
        run_access(1'b0, 32'h0000_3004, 4'b1111, 32'h0, 1'b0, TO - 1, -1, 32'hCAFE_F00D);
        check("ack_at_expiry", rdata, 32'hCAFE_F00D);
        run_access(1'b0, 32'h0000_5008, 4'b0001, 32'h0, 1'b0, 3, 1, 32'h1111_11FF);
        check("flush_kept", rdata, 32'hCAFE_F00D);
        reset_mid_busy();

        for (int t = 0; t < 60; t++) begin
            logic [3:0] s;
            int dly, fl;
            s   = ($urandom_range(0, 6) == 6) ? 4'b1111 : sel_tab[$urandom_range(0, 5)];
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            if ($urandom_range(0, 7) == 0)
                no_access($urandom_range(0, 1), ($urandom_range(0, 1) == 1) ? 4'b0000 : s, 1'b1);
            run_access($urandom_range(0, 1), $urandom, s, $urandom, $urandom_range(0, 1),
                       dly, fl, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
